// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, clocked frame out, ACK check.
// Lines are driven open-drain through output-enables; all outputs are registered.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYC = 350,
    parameter int unsigned TIMEOUT_CYC = 52500
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int unsigned INH_W = (INHIBIT_CYC > 1) ? $clog2(INHIBIT_CYC) : 1;
    localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_RELEASE,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t           state_q;
    logic [7:0]       data_q;
    logic             par_q;
    logic [3:0]       bit_cnt_q;
    logic [INH_W-1:0] inh_q;
    logic [TMO_W-1:0] tmo_q;
    logic             tx_ready_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic             clk_oe_q;
    logic             dat_oe_q;

    logic clk_meta_q, clk_sync_q, clk_prev_q;
    logic dat_meta_q, dat_sync_q;

    logic fall;
    logic accept;
    logic tmo_hit;

    assign fall    = clk_prev_q & ~clk_sync_q;
    assign accept  = tx_valid & tx_ready_q;
    assign tmo_hit = (tmo_q == TMO_LAST);

    // Idle bus level is high, so synchronizers reset to 1 to avoid a false fall.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            clk_meta_q <= ps2_clk_in;
            clk_sync_q <= clk_meta_q;
            clk_prev_q <= clk_sync_q;
            dat_meta_q <= ps2_dat_in;
            dat_sync_q <= dat_meta_q;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q    <= S_IDLE;
            data_q     <= '0;
            par_q      <= 1'b0;
            bit_cnt_q  <= '0;
            inh_q      <= '0;
            tmo_q      <= '0;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        data_q     <= tx_data;
                        par_q      <= ~^tx_data;
                        bit_cnt_q  <= '0;
                        inh_q      <= '0;
                        tmo_q      <= '0;
                        tx_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        clk_oe_q   <= 1'b1;
                        dat_oe_q   <= 1'b0;
                        state_q    <= S_INHIBIT;
                    end else begin
                        tx_ready_q <= 1'b1;
                    end
                end
                S_INHIBIT: begin
                    if (inh_q == INH_LAST) begin
                        dat_oe_q <= 1'b1;
                        state_q  <= S_RTS;
                    end else begin
                        inh_q <= inh_q + 1'b1;
                    end
                end
                S_RTS: begin
                    clk_oe_q <= 1'b0;
                    tmo_q    <= '0;
                    state_q  <= S_RELEASE;
                end
                S_RELEASE, S_ACK, S_WAIT_IDLE: begin
                    // Timeout is checked first so it wins over a coincident fall.
                    if (tmo_hit) begin
                        clk_oe_q <= 1'b0;
                        dat_oe_q <= 1'b0;
                        err_q    <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                        case (state_q)
                            S_RELEASE: begin
                                if (fall) begin
                                    bit_cnt_q <= bit_cnt_q + 1'b1;
                                    if (bit_cnt_q < 4'd8) begin
                                        dat_oe_q <= ~data_q[bit_cnt_q[2:0]];
                                    end else if (bit_cnt_q == 4'd8) begin
                                        dat_oe_q <= ~par_q;
                                    end else begin
                                        dat_oe_q <= 1'b0;
                                        state_q  <= S_ACK;
                                    end
                                end
                            end
                            S_ACK: begin
                                if (fall) begin
                                    bit_cnt_q <= bit_cnt_q + 1'b1;
                                    if (dat_sync_q) begin
                                        err_q   <= 1'b1;
                                        busy_q  <= 1'b0;
                                        state_q <= S_IDLE;
                                    end else begin
                                        state_q <= S_WAIT_IDLE;
                                    end
                                end
                            end
                            S_WAIT_IDLE: begin
                                if (clk_sync_q && dat_sync_q) begin
                                    done_q  <= 1'b1;
                                    busy_q  <= 1'b0;
                                    state_q <= S_IDLE;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx_ready   = tx_ready_q;
    assign busy       = busy_q;
    assign tx_done    = done_q;
    assign tx_error   = err_q;
    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain bus and a simple keyboard model.
module tb_ps2_host_tx;

    localparam int INH  = 350;
    localparam int TMO  = 52500;
    localparam int HALF = 70;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, tx_done, tx_error;
    logic       ps2_clk_oe, ps2_dat_oe;
    logic       ps2_clk_in, ps2_dat_in;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;

    assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

    ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO)) dut (
        .clk        (clk),
        .nreset     (nreset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .tx_done    (tx_done),
        .tx_error   (tx_error),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0, inh_cnt = 0, rts_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_done === 1'b1) done_cnt++;
        if (tx_error === 1'b1) err_cnt++;
        if (tx_done === 1'b1 && tx_error === 1'b1) both_cnt++;
        if (ps2_clk_oe === 1'b1 && ps2_dat_oe === 1'b0) inh_cnt++;
        if (ps2_clk_oe === 1'b1 && ps2_dat_oe === 1'b1) rts_cnt++;
    end

    task automatic send_byte(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Keyboard model: waits for RTS release, clocks 11 bits, samples the line before each rise.
    // bits[0]=start, [8:1]=data LSB first, [9]=parity, [10]=stop.
    task automatic device_frame(input logic nack, output logic [10:0] bits, output logic ok);
        int k = 0;
        ok = 1'b0;
        bits = '0;
        while (!ok && k < 2000) begin
            @(negedge clk);
            k++;
            if (ps2_clk_oe === 1'b0 && ps2_dat_oe === 1'b1) ok = 1'b1;
        end
        if (ok) begin
            repeat (20) @(negedge clk);
            bits[0] = ps2_dat_in;
            for (int i = 1; i <= 11; i++) begin
                if (i == 11) begin
                    dev_dat_low = ~nack;
                    repeat (5) @(negedge clk);
                end
                dev_clk_low = 1'b1;
                repeat (HALF) @(negedge clk);
                if (i <= 10) bits[i] = ps2_dat_in;
                dev_clk_low = 1'b0;
                if (i == 11) dev_dat_low = 1'b0;
                else repeat (HALF) @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_tests++;
        if ({tx_ready, busy, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_held: got %b expected 100000",
                     {tx_ready, busy, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe});
        end
        nreset = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({tx_ready, busy, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_released: got %b expected 100000",
                     {tx_ready, busy, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe});
        end
    endtask

    task automatic test_send(input logic [7:0] d, input logic par, input string nm);
        logic [10:0] bits;
        logic        ok;
        logic        seen = 1'b0;
        int inh0 = inh_cnt, rts0 = rts_cnt, done0 = done_cnt, err0 = err_cnt;
        int k = 0;
        send_byte(d);
        n_tests++;
        if ({ps2_clk_oe, busy, tx_ready} !== 3'b110) begin
            n_fail++;
            $display("FAIL %s_accept_latency: got oe/busy/ready=%b expected 110", nm, {ps2_clk_oe, busy, tx_ready});
        end
        device_frame(1'b0, bits, ok);
        n_tests++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_release: got no RTS release expected release within 2000 cycles", nm);
        end
        n_tests++;
        if (bits !== {1'b1, par, d, 1'b0}) begin
            n_fail++;
            $display("FAIL %s_bits: got %b expected %b", nm, bits, {1'b1, par, d, 1'b0});
        end
        while (!seen && k < 300) begin
            @(negedge clk);
            k++;
            if (tx_done === 1'b1) seen = 1'b1;
        end
        n_tests++;
        if (seen !== 1'b1 || tx_ready !== 1'b0 || tx_error !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_done_pulse: got seen=%b ready=%b err=%b expected 1 0 0", nm, seen, tx_ready, tx_error);
        end
        @(negedge clk);
        n_tests++;
        if (tx_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_ready_after: got ready=%b busy=%b expected 1 0", nm, tx_ready, busy);
        end
        n_tests++;
        if (inh_cnt - inh0 !== INH || rts_cnt - rts0 !== 1) begin
            n_fail++;
            $display("FAIL %s_inhibit_len: got inhibit=%0d rts=%0d expected %0d 1", nm, inh_cnt - inh0, rts_cnt - rts0, INH);
        end
        n_tests++;
        if (done_cnt - done0 !== 1 || err_cnt !== err0) begin
            n_fail++;
            $display("FAIL %s_pulse_count: got done=%0d err=%0d expected 1 0", nm, done_cnt - done0, err_cnt - err0);
        end
    endtask

    task automatic test_timeout();
        logic seen = 1'b0;
        int done0 = done_cnt;
        int rel = 0, k = 0;
        send_byte(8'h55);
        while (!seen && k < 2000) begin
            @(negedge clk);
            k++;
            if (ps2_clk_oe === 1'b0 && ps2_dat_oe === 1'b1) seen = 1'b1;
        end
        rel = cyc;
        n_tests++;
        if (seen !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_release: got no release expected release");
        end
        seen = 1'b0;
        k = 0;
        while (!seen && k < TMO + 200) begin
            @(negedge clk);
            k++;
            if (tx_error === 1'b1) seen = 1'b1;
        end
        n_tests++;
        if (seen !== 1'b1 || cyc - rel !== TMO) begin
            n_fail++;
            $display("FAIL timeout_latency: got seen=%b cycles=%0d expected 1 %0d", seen, cyc - rel, TMO);
        end
        n_tests++;
        if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0 || done_cnt !== done0) begin
            n_fail++;
            $display("FAIL timeout_lines: got oe=%b%b done=%0d expected 00 0", ps2_clk_oe, ps2_dat_oe, done_cnt - done0);
        end
        @(negedge clk);
        n_tests++;
        if (tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_ready: got %b expected 1", tx_ready);
        end
    endtask

    task automatic test_nack();
        logic [10:0] bits;
        logic        ok;
        int done0 = done_cnt, err0 = err_cnt;
        send_byte(8'hF4);
        device_frame(1'b1, bits, ok);
        repeat (10) @(negedge clk);
        n_tests++;
        if (ok !== 1'b1 || err_cnt - err0 !== 1 || done_cnt !== done0) begin
            n_fail++;
            $display("FAIL nack_pulses: got ok=%b err=%0d done=%0d expected 1 1 0", ok, err_cnt - err0, done_cnt - done0);
        end
        n_tests++;
        if (tx_ready !== 1'b1 || busy !== 1'b0 || ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL nack_idle: got ready=%b busy=%b oe=%b%b expected 1 0 00", tx_ready, busy, ps2_clk_oe, ps2_dat_oe);
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] b1, b2;
        logic        ok1, ok2;
        logic        seen = 1'b0;
        int done0 = done_cnt, err0 = err_cnt;
        int k = 0;
        @(negedge clk);
        tx_data  = 8'h12;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data  = 8'hA7;
        device_frame(1'b0, b1, ok1);
        while (!seen && k < 300) begin
            @(negedge clk);
            k++;
            if (tx_ready === 1'b1) seen = 1'b1;
        end
        @(negedge clk);
        tx_valid = 1'b0;
        n_tests++;
        if (ok1 !== 1'b1 || b1 !== {1'b1, 1'b1, 8'h12, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_first_bits: got ok=%b %b expected 1 %b", ok1, b1, {1'b1, 1'b1, 8'h12, 1'b0});
        end
        n_tests++;
        if (seen !== 1'b1 || busy !== 1'b1 || done_cnt - done0 !== 1) begin
            n_fail++;
            $display("FAIL b2b_second_accept: got ready_seen=%b busy=%b done=%0d expected 1 1 1", seen, busy, done_cnt - done0);
        end
        device_frame(1'b0, b2, ok2);
        repeat (10) @(negedge clk);
        n_tests++;
        if (ok2 !== 1'b1 || b2 !== {1'b1, 1'b0, 8'hA7, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_second_bits: got ok=%b %b expected 1 %b", ok2, b2, {1'b1, 1'b0, 8'hA7, 1'b0});
        end
        n_tests++;
        if (done_cnt - done0 !== 2 || err_cnt !== err0 || tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_done_count: got done=%0d err=%0d ready=%b expected 2 0 1", done_cnt - done0, err_cnt - err0, tx_ready);
        end
    endtask

    task automatic test_reset_midframe();
        logic seen = 1'b0;
        int done0 = done_cnt, err0 = err_cnt;
        int k = 0;
        send_byte(8'h00);
        while (!seen && k < 2000) begin
            @(negedge clk);
            k++;
            if (ps2_clk_oe === 1'b0 && ps2_dat_oe === 1'b1) seen = 1'b1;
        end
        repeat (20) @(negedge clk);
        for (int i = 1; i <= 3; i++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        dev_clk_low = 1'b1;
        repeat (10) @(negedge clk);
        n_tests++;
        if (seen !== 1'b1 || ps2_dat_oe !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_bit4: got seen=%b dat_oe=%b busy=%b expected 1 1 1", seen, ps2_dat_oe, busy);
        end
        #2 nreset = 1'b0;
        #1;
        n_tests++;
        if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0 || tx_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_async: got oe=%b%b ready=%b busy=%b expected 00 1 0", ps2_clk_oe, ps2_dat_oe, tx_ready, busy);
        end
        dev_clk_low = 1'b0;
        repeat (4) @(negedge clk);
        nreset = 1'b1;
        repeat (4) @(negedge clk);
        n_tests++;
        if (done_cnt !== done0 || err_cnt !== err0) begin
            n_fail++;
            $display("FAIL rst_mid_no_pulse: got done=%0d err=%0d expected 0 0", done_cnt - done0, err_cnt - err0);
        end
        test_send(8'hFF, 1'b1, "after_reset_FF");
    endtask

    initial begin
        test_reset();
        test_send(8'hED, 1'b1, "send_ED");
        test_send(8'h07, 1'b0, "send_07");
        test_send(8'h00, 1'b1, "send_00");
        test_send(8'hFF, 1'b1, "send_FF");
        test_timeout();
        test_nack();
        test_back_to_back();
        test_reset_midframe();
        n_tests++;
        if (both_cnt !== 0) begin
            n_fail++;
            $display("FAIL done_error_exclusive: got %0d overlaps expected 0", both_cnt);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
